// File: rtl/tpu_array.sv
// tpu_array: 4x4 output-stationary-free systolic array of signed MAC PEs.
// Weights are shifted down the columns while control=1. Data moves left to
// right along the rows, and partial sums move top to bottom.
// Each bottom-row PE drives a registered 8-bit normalizer.
//
// Ports:
//   clk            - rising-edge clock
//   rst_n          - asynchronous active-low reset
//   control        - 1: weight-load mode (psums cleared), 0: compute mode
//   data_arr       - 4 lanes of bit_width; lane i feeds row i
//   wt_arr         - 4 lanes of bit_width; lane j feeds column j weight chain
//   acc_out        - {pe33_out, pe32_out, pe31_out, pe30_out}
//   pe3c_out       - partial sum of bottom-row PE(3,c)
//   pe3c_norm_out  - clamped (pe3c_out >>> 3) as an 8-bit pixel, one cycle later
module tpu_array #(
  parameter int bit_width = 16,
  parameter int acc_width = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       control,
  input  logic [4*bit_width-1:0]     data_arr,
  input  logic [4*bit_width-1:0]     wt_arr,
  output logic [4*acc_width-1:0]     acc_out,
  output logic [acc_width-1:0]       pe30_out,
  output logic [acc_width-1:0]       pe31_out,
  output logic [acc_width-1:0]       pe32_out,
  output logic [acc_width-1:0]       pe33_out,
  output logic [7:0]                 pe30_norm_out,
  output logic [7:0]                 pe31_norm_out,
  output logic [7:0]                 pe32_norm_out,
  output logic [7:0]                 pe33_norm_out
);

  localparam int pw = 2 * bit_width;

  logic signed [bit_width-1:0] w_q  [4][4];
  logic signed [bit_width-1:0] d_q  [4][4];
  logic signed [acc_width-1:0] p_q  [4][4];
  logic [7:0]                  norm_q [4];

  logic signed [bit_width-1:0] din      [4][4];
  logic signed [acc_width-1:0] pin      [4][4];
  logic [pw-1:0]               prod     [4][4];
  logic signed [acc_width-1:0] psum_nxt [4][4];
  logic [acc_width-1:0]        shifted  [4];
  logic [7:0]                  norm_nxt [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      din[r][0] = data_arr[r*bit_width +: bit_width];
      for (int c = 1; c < 4; c++) din[r][c] = d_q[r][c-1];
    end
    for (int c = 0; c < 4; c++) begin
      pin[0][c] = '0;
      for (int r = 1; r < 4; r++) pin[r][c] = p_q[r-1][c];
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        // Low 2*bit_width bits of the product of sign-extended operands
        // equal the signed product, so an unsigned multiply is sufficient.
        prod[r][c] = {{bit_width{din[r][c][bit_width-1]}}, din[r][c]} *
                     {{bit_width{w_q[r][c][bit_width-1]}}, w_q[r][c]};
        psum_nxt[r][c] = pin[r][c] +
                         {{(acc_width-pw){prod[r][c][pw-1]}}, prod[r][c]};
      end
    end
    for (int c = 0; c < 4; c++) begin
      shifted[c] = p_q[3][c] >>> 3;
      // A non-negative value exceeds 255 exactly when any bit above 7 is set.
      if (p_q[3][c][acc_width-1])
        norm_nxt[c] = 8'd0;
      else if (|shifted[c][acc_width-1:8])
        norm_nxt[c] = 8'd255;
      else
        norm_nxt[c] = shifted[c][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          w_q[r][c] <= '0;
          d_q[r][c] <= '0;
          p_q[r][c] <= '0;
        end
      end
      for (int c = 0; c < 4; c++) norm_q[c] <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          d_q[r][c] <= din[r][c];
          p_q[r][c] <= control ? '0 : psum_nxt[r][c];
        end
      end
      if (control) begin
        for (int c = 0; c < 4; c++) begin
          w_q[0][c] <= wt_arr[c*bit_width +: bit_width];
          for (int r = 1; r < 4; r++) w_q[r][c] <= w_q[r-1][c];
        end
      end
      for (int c = 0; c < 4; c++) norm_q[c] <= norm_nxt[c];
    end
  end

  assign pe30_out = p_q[3][0];
  assign pe31_out = p_q[3][1];
  assign pe32_out = p_q[3][2];
  assign pe33_out = p_q[3][3];
  assign acc_out  = {pe33_out, pe32_out, pe31_out, pe30_out};

  assign pe30_norm_out = norm_q[0];
  assign pe31_norm_out = norm_q[1];
  assign pe32_norm_out = norm_q[2];
  assign pe33_norm_out = norm_q[3];

endmodule

// File: tb/tb_tpu_array.sv
// tb_tpu_array: directed self-checking bench for tpu_array.
// Drives reset, weight loads, a skewed stream, saturation/clamp corners and a
// mid-stream reset, comparing against hand-computed values.
module tb_tpu_array;
  localparam int BW = 16;
  localparam int AW = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              control;
  logic [4*BW-1:0]   data_arr;
  logic [4*BW-1:0]   wt_arr;
  logic [4*AW-1:0]   acc_out;
  logic [AW-1:0]     pe30_out, pe31_out, pe32_out, pe33_out;
  logic [7:0]        pe30_norm_out, pe31_norm_out, pe32_norm_out, pe33_norm_out;

  int n_tests = 0;
  int n_fail  = 0;

  tpu_array #(.bit_width(BW), .acc_width(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .control       (control),
    .data_arr      (data_arr),
    .wt_arr        (wt_arr),
    .acc_out       (acc_out),
    .pe30_out      (pe30_out),
    .pe31_out      (pe31_out),
    .pe32_out      (pe32_out),
    .pe33_out      (pe33_out),
    .pe30_norm_out (pe30_norm_out),
    .pe31_norm_out (pe31_norm_out),
    .pe32_norm_out (pe32_norm_out),
    .pe33_norm_out (pe33_norm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] norms();
    return {128'd0, pe33_norm_out, pe32_norm_out, pe31_norm_out, pe30_norm_out};
  endfunction

  task automatic load_w(input logic [63:0] v0, input logic [63:0] v1,
                        input logic [63:0] v2, input logic [63:0] v3);
    control = 1'b1;
    wt_arr = v0; tick();
    wt_arr = v1; tick();
    wt_arr = v2; tick();
    wt_arr = v3; tick();
    check("load_psum_zero", acc_out, 160'd0);
    control = 1'b0;
    wt_arr = 64'hDEAD_BEEF_1234_5678;
  endtask

  logic [63:0]  d;
  logic [159:0] exp_acc;
  logic [159:0] exp_norm;
  int           prev [4];
  int           k, v;

  initial begin
    // Reset with random inputs
    rst_n    = 1'b0;
    control  = 1'($urandom);
    data_arr = {$urandom, $urandom};
    wt_arr   = {$urandom, $urandom};
    #3;
    check("reset_acc", acc_out, 160'd0);
    check("reset_norm", norms(), 160'd0);
    tick();
    data_arr = {$urandom, $urandom};
    tick();
    check("reset_acc_clocked", acc_out, 160'd0);
    check("reset_norm_clocked", norms(), 160'd0);

    data_arr = '0;
    wt_arr   = '0;
    control  = 1'b1;
    rst_n    = 1'b1;
    tick();

    // Diagonal weights of 10
    load_w(64'h000A_0000_0000_0000, 64'h0000_000A_0000_0000,
           64'h0000_0000_000A_0000, 64'h0000_0000_0000_000A);

    // Skewed stream: row r element of vector k is 4r+k, entering at edge k+r
    for (int c = 0; c < 4; c++) prev[c] = 0;
    for (int j = 0; j < 12; j++) begin
      d = '0;
      for (int r = 0; r < 4; r++)
        if (j - r >= 0 && j - r <= 3) d[r*BW +: BW] = 16'(4*r + j - r);
      data_arr = d;
      tick();
      exp_acc  = '0;
      exp_norm = '0;
      for (int c = 0; c < 4; c++) begin
        k = j - 3 - c;
        v = (k >= 0 && k <= 3) ? 10 * (4*c + k) : 0;
        exp_acc[c*AW +: AW]  = 40'(v);
        exp_norm[c*8 +: 8]   = 8'(prev[c] / 8);
        prev[c] = v;
      end
      check($sformatf("stream_acc_%0d", j), acc_out, exp_acc);
      check($sformatf("stream_norm_%0d", j), norms(), exp_norm);
    end
    check("stream_pe30_port", {120'd0, pe30_out}, 160'd0);

    // Saturation: 0x7FFF * 0x7FFF
    load_w(64'd0, 64'd0, 64'd0, 64'h0000_0000_0000_7FFF);
    data_arr = 64'h0000_0000_0000_7FFF;
    repeat (4) tick();
    check("sat_pe30", {120'd0, pe30_out}, {120'd0, 40'h00_3FFF_0001});
    check("sat_acc", acc_out, {120'd0, 40'h00_3FFF_0001});
    tick();
    check("sat_norm", norms(), 160'd255);

    // Negative clamp: -1 * 5
    load_w(64'd0, 64'd0, 64'd0, 64'h0000_0000_0000_FFFF);
    data_arr = 64'h0000_0000_0000_0005;
    repeat (5) tick();
    check("neg_pe30", {120'd0, pe30_out}, {120'd0, 40'hFF_FFFF_FFFB});
    check("neg_norm", norms(), 160'd0);

    // Normalizer boundaries with unit weight
    load_w(64'd0, 64'd0, 64'd0, 64'h0000_0000_0000_0001);
    data_arr = 64'd2039;
    repeat (5) tick();
    check("norm_2039", norms(), 160'd254);
    data_arr = 64'd2047;
    repeat (5) tick();
    check("norm_2047", norms(), 160'd255);
    data_arr = 64'd2048;
    repeat (5) tick();
    check("norm_2048", norms(), 160'd255);
    data_arr = 64'd80;
    repeat (5) tick();
    check("norm_80", norms(), 160'd10);

    // Reset mid-stream
    load_w(64'h000A_0000_0000_0000, 64'h0000_000A_0000_0000,
           64'h0000_0000_000A_0000, 64'h0000_0000_0000_000A);
    for (int j = 0; j < 5; j++) begin
      d = '0;
      for (int r = 0; r < 4; r++)
        if (j - r >= 0 && j - r <= 3) d[r*BW +: BW] = 16'(4*r + j - r);
      data_arr = d;
      tick();
    end
    check("pre_reset_nonzero", {159'd0, (acc_out != 160'd0)}, 160'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_acc", acc_out, 160'd0);
    check("midreset_norm", norms(), 160'd0);
    tick();
    rst_n    = 1'b1;
    control  = 1'b0;
    data_arr = 64'h0003_0002_0001_0004;
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("postreset_acc_%0d", j), acc_out, 160'd0);
    end
    check("postreset_norm", norms(), 160'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_array.md
TPU_ARRAY -- requirements
Module: tpu_array

Interface
REQ-001 Parameter bit_width, default 16: width of each data and weight lane.
REQ-002 Parameter acc_width, default 40: width of each partial-sum / column result.
REQ-003 Array depth SHALL be fixed at 4 (4x4 PEs, indexed row r 0..3, column c 0..3).
REQ-004 clk  input  1  sole clock; all registers update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 control  input  1  1 = weight-load mode, 0 = compute mode.
REQ-007 data_arr  input  4*bit_width  lane i (bits [16i+15:16i]) feeds row i.
REQ-008 wt_arr  input  4*bit_width  lane j (bits [16j+15:16j]) feeds column j weight chain.
REQ-009 acc_out  output  4*acc_width  {pe33_out, pe32_out, pe31_out, pe30_out}.
REQ-010 pe30_out..pe33_out  output  acc_width each  partial-sum output of bottom-row PE(3,c).
REQ-011 pe30_norm_out..pe33_norm_out  output  8 each  normalized 8-bit pixel for column c.

Function
REQ-012 Each PE SHALL hold registers: weight w, data_out, psum_out (acc_width), all signed two's complement.
REQ-013 Weight load (control=1): each edge w[0][c] <= wt_arr lane c; w[r][c] <= w[r-1][c] for r=1..3 (weights shift down).
REQ-014 After 4 load cycles, row r holds the lane value presented on load cycle 4-r.
REQ-015 control=0: all weights SHALL hold unchanged indefinitely.
REQ-016 Data flow: PE(r,0) data input = data_arr lane r; PE(r,c) data input = data_out of PE(r,c-1); data_out <= data input each edge, regardless of control.
REQ-017 Compute: psum_out <= psum_in + data_in*w, product sign-extended to acc_width, sum wraps modulo 2^acc_width.
REQ-018 psum_in of row 0 SHALL be 0; psum_in of PE(r,c) = psum_out of PE(r-1,c).
REQ-019 While control=1, every psum_out SHALL be loaded with 0.
REQ-020 pe3c_out SHALL equal psum_out of PE(3,c) directly (no extra register).
REQ-021 Latency: with inputs skewed (row r delayed r cycles), a data vector whose row-0 element enters on edge t produces column c result on pe3c_out after edge t+3+c.
REQ-022 Normalizer per column, registered: norm <= 0 if pe3c_out < 0; 255 if (pe3c_out >>> 3) > 255; else (pe3c_out >>> 3)[7:0].
REQ-023 pe3c_norm_out SHALL therefore lag pe3c_out by exactly one cycle.
REQ-024 Unknown/X data lanes SHALL only affect PEs they reach; no requirement on such outputs.

Reset
REQ-025 rst_n=0 SHALL immediately clear all weights, data_out, psum_out and norm registers to 0, independent of clk.
REQ-026 During reset all outputs SHALL read 0; first update occurs on the first rising edge with rst_n=1.
REQ-027 Reset asserted mid-load or mid-stream SHALL discard all state; weights must be reloaded.

Verification
REQ-028 Reset: rst_n=0 with random inputs -> acc_out=0, all norm outputs=0.
REQ-029 Diagonal load: control=1 for 4 cycles, wt_arr = lane3=0x000A, then lane2, lane1, lane0 -> w[r][r]=10, all other weights 0; holds after control=0.
REQ-030 Identity stream: skewed rows row0=0,1,2,3, row1=4,5,6,7 -> pe30_out sequence 0,10,20,30, pe31_out 40,50,60,70 one cycle later; pe30_norm_out 0,1,2,3 one cycle after pe30_out.
REQ-031 Saturation: w[0][0]=0x7FFF, data 0x7FFF -> pe30_out=0x3FFF0001, pe30_norm_out=255.
REQ-032 Negative clamp: w[0][0]=0xFFFF (-1), data 5 -> pe30_out=-5 (0xFFFFFFFFFB), pe30_norm_out=0.
REQ-033 Reset mid-stream: assert rst_n=0 during REQ-030 stream -> all outputs 0 at once; after release with control=0, pe3c_out stays 0 for any data.
